// File: rtl/wb_tag_pipeline.sv
// rtl/wb_tag_pipeline.sv - carries dest/wb_en/mem_en tags ID->EXE->MEM->WB and derives freeze/flush/stall controls.
// Optional perf counters (hazard_stall_cnt, mem_stall_cnt) when WB_TAG_PERF_EN is defined.
module wb_tag_pipeline #(
  parameter int TAG_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_en,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic [TAG_W-1:0] Exe_Dest,
  output logic             Exe_WB_EN,
  output logic [TAG_W-1:0] Mem_Dest,
  output logic             Mem_WB_EN,
  output logic [TAG_W-1:0] Wb_Dest,
  output logic             Wb_WB_EN,
  output logic             freeze_if_id,
  output logic             freeze_all,
  output logic             flush_if_id,
  output logic             mem_timeout
`ifdef WB_TAG_PERF_EN
  ,
  output logic [31:0]      hazard_stall_cnt,
  output logic [31:0]      mem_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT + 1);

  typedef struct packed {
    logic [TAG_W-1:0] dest;
    logic             wb_en;
    logic             mem_en;
  } stage_t;

  typedef enum logic {S_RUN, S_WAIT} state_t;

  stage_t           exe_q, exe_d, mem_q, mem_d;
  logic [TAG_W-1:0] wb_dest_q, wb_dest_d;
  logic             wb_en_q, wb_en_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             stall_mem;

  assign stall_mem = mem_q.mem_en & ~mem_ready;

  always_comb begin
    exe_d        = exe_q;
    mem_d        = mem_q;
    wb_dest_d    = wb_dest_q;
    wb_en_d      = wb_en_q;
    freeze_all   = stall_mem;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    if (stall_mem) begin
      freeze_if_id = 1'b1;
    end else begin
      mem_d     = exe_q;
      wb_dest_d = mem_q.dest;
      wb_en_d   = mem_q.wb_en;
      // Wrong-path ID instruction: the branch wins over any hazard on it.
      if (branch_taken) begin
        exe_d       = '0;
        flush_if_id = 1'b1;
      end else if (hazard) begin
        exe_d        = '0;
        freeze_if_id = 1'b1;
      end else begin
        exe_d = '{dest: id_dest, wb_en: id_wb_en, mem_en: id_mem_en};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (stall_mem) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
    timeout_d = timeout_q | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q     <= '0;
      mem_q     <= '0;
      wb_dest_q <= '0;
      wb_en_q   <= 1'b0;
      state_q   <= S_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      exe_q     <= exe_d;
      mem_q     <= mem_d;
      wb_dest_q <= wb_dest_d;
      wb_en_q   <= wb_en_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign Exe_Dest    = exe_q.dest;
  assign Exe_WB_EN   = exe_q.wb_en;
  assign Mem_Dest    = mem_q.dest;
  assign Mem_WB_EN   = mem_q.wb_en;
  assign Wb_Dest     = wb_dest_q;
  assign Wb_WB_EN    = wb_en_q;
  assign mem_timeout = timeout_q;

`ifdef WB_TAG_PERF_EN
  logic [31:0] haz_cnt_q, mstall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      haz_cnt_q    <= '0;
      mstall_cnt_q <= '0;
    end else begin
      if (hazard & ~branch_taken & ~freeze_all) haz_cnt_q <= haz_cnt_q + 32'd1;
      if (freeze_all) mstall_cnt_q <= mstall_cnt_q + 32'd1;
    end
  end

  assign hazard_stall_cnt = haz_cnt_q;
  assign mem_stall_cnt    = mstall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_tag_pipeline.sv
// tb/tb_wb_tag_pipeline.sv - table-driven and sequence checks with a write-back scoreboard for wb_tag_pipeline.
module tb_wb_tag_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_dest;
  logic       id_wb_en, id_mem_en, hazard, branch_taken, mem_ready;
  logic [3:0] Exe_Dest, Mem_Dest, Wb_Dest;
  logic       Exe_WB_EN, Mem_WB_EN, Wb_WB_EN;
  logic       freeze_if_id, freeze_all, flush_if_id, mem_timeout;
`ifdef WB_TAG_PERF_EN
  logic [31:0] hazard_stall_cnt, mem_stall_cnt;
`endif

  wb_tag_pipeline #(.TAG_W(4), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_en(id_mem_en),
    .hazard(hazard), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .Exe_Dest(Exe_Dest), .Exe_WB_EN(Exe_WB_EN),
    .Mem_Dest(Mem_Dest), .Mem_WB_EN(Mem_WB_EN),
    .Wb_Dest(Wb_Dest), .Wb_WB_EN(Wb_WB_EN),
    .freeze_if_id(freeze_if_id), .freeze_all(freeze_all),
    .flush_if_id(flush_if_id), .mem_timeout(mem_timeout)
`ifdef WB_TAG_PERF_EN
    , .hazard_stall_cnt(hazard_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  logic fa_pre, fi_pre, fl_pre;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] d;
    logic       w, h, b;
    logic       fi, fl;
    logic [3:0] ed;
    logic       ew;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, capture combinational controls, then retire-check WB after the edge.
  task automatic cycle(input logic [3:0] d, input logic w, input logic m,
                       input logic h, input logic b, input logic r);
    @(negedge clk);
    id_dest = d; id_wb_en = w; id_mem_en = m; hazard = h; branch_taken = b; mem_ready = r;
    #1;
    fa_pre = freeze_all; fi_pre = freeze_if_id; fl_pre = flush_if_id;
    @(posedge clk);
    #1;
    if (!rst && !fa_pre && Wb_WB_EN) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got dest %0d expected no write-back", Wb_Dest);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (Wb_Dest !== e) begin
          errors++;
          $display("FAIL wb_dest: got %0d expected %0d", Wb_Dest, e);
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  1'b1};
    tbl[1] = '{4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5,  1'b1};
    tbl[2] = '{4'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0};
    tbl[3] = '{4'd9,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0};
    tbl[4] = '{4'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  1'b0};
    tbl[5] = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
    tbl[6] = '{4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1};
    tbl[7] = '{4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4,  1'b1};

    rst = 1'b1;
    cycle(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_exe_wb", Exe_WB_EN, 0);
    chk("rst_mem_wb", Mem_WB_EN, 0);
    chk("rst_wb_wb", Wb_WB_EN, 0);
    chk("rst_dests", {Exe_Dest, Mem_Dest, Wb_Dest}, 0);
    chk("rst_timeout", mem_timeout, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].d, tbl[i].w, 1'b0, tbl[i].h, tbl[i].b, 1'b1);
      if (tbl[i].ew) exp_q.push_back(tbl[i].ed);
      chk($sformatf("tbl%0d_freeze_if_id", i), fi_pre, tbl[i].fi);
      chk($sformatf("tbl%0d_flush_if_id", i), fl_pre, tbl[i].fl);
      chk($sformatf("tbl%0d_freeze_all", i), fa_pre, 0);
      chk($sformatf("tbl%0d_exe_dest", i), Exe_Dest, tbl[i].ed);
      chk($sformatf("tbl%0d_exe_wb", i), Exe_WB_EN, tbl[i].ew);
      chk($sformatf("tbl%0d_mem_dest", i), Mem_Dest, (i == 0) ? 4'd0 : tbl[i-1].ed);
      chk($sformatf("tbl%0d_mem_wb", i), Mem_WB_EN, (i == 0) ? 1'b0 : tbl[i-1].ew);
    end

    // Load reaches MEM, then three not-ready cycles with hazard/branch noise.
    cycle(4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); exp_q.push_back(4'd6);
    chk("ld_exe_dest", Exe_Dest, 6);
    cycle(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); exp_q.push_back(4'd8);
    chk("ld_mem_dest", Mem_Dest, 6);
    for (int k = 0; k < 3; k++) begin
      cycle(4'd11, 1'b1, 1'b0, (k != 2), (k != 1), 1'b0);
      chk($sformatf("stall%0d_freeze_all", k), fa_pre, 1);
      chk($sformatf("stall%0d_freeze_if_id", k), fi_pre, 1);
      chk($sformatf("stall%0d_flush", k), fl_pre, 0);
      chk($sformatf("stall%0d_exe", k), {Exe_Dest, Exe_WB_EN}, {4'd8, 1'b1});
      chk($sformatf("stall%0d_mem", k), {Mem_Dest, Mem_WB_EN}, {4'd6, 1'b1});
      chk($sformatf("stall%0d_wb", k), {Wb_Dest, Wb_WB_EN}, {4'd4, 1'b1});
    end
    cycle(4'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("release_freeze_all", fa_pre, 0);
    chk("release_hazard_seen", fi_pre, 1);
    chk("release_exe_bubble", Exe_WB_EN, 0);
    chk("release_mem_dest", Mem_Dest, 8);
    chk("release_timeout", mem_timeout, 0);
    cycle(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); exp_q.push_back(4'd11);

    // Long wait: timeout after the 16th wait cycle, sticky afterwards.
    cycle(4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); exp_q.push_back(4'd12);
    cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("wait%0d_timeout", k), mem_timeout, (k >= 16));
    end
    cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wait_release_freeze", fa_pre, 0);
    chk("timeout_sticky", mem_timeout, 1);
    for (int k = 0; k < 3; k++) cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("timeout_sticky_late", mem_timeout, 1);
    chk("queue_empty_pre_rst", exp_q.size(), 0);

    // Reset in the middle of a stall drops the in-flight load.
    cycle(4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prerst_stalled", fa_pre, 1);
    rst = 1'b1;
    cycle(4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("midrst_stages", {Exe_WB_EN, Mem_WB_EN, Wb_WB_EN, Exe_Dest, Mem_Dest, Wb_Dest}, 0);
    chk("midrst_timeout", mem_timeout, 0);
    chk("midrst_no_freeze", freeze_all, 0);

    // Two counted hazard cycles, then three stall cycles (hazard during stall not counted).
    cycle(4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); exp_q.push_back(4'd7);
    cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef WB_TAG_PERF_EN
    chk("perf_hazard_cnt", hazard_stall_cnt, 2);
    chk("perf_mem_stall_cnt", mem_stall_cnt, 3);
`endif
    for (int k = 0; k < 4; k++) cycle(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("queue_empty_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
